// File: rtl/asi_usr_mem.sv
// asi_usr_mem: user-side memory slave behind the AXI slave interface.
// It takes single-port requests and supports byte-strobed writes.
// Read data appears SLV_WS cycles after m_re.
// Accesses outside the address window and same-cycle write/read collisions
// are reported through sticky flags.
// Accepted accesses are tallied in saturating counters.
module asi_usr_mem #(
  parameter int                AXI_DW    = 128,
  parameter int                AXI_AW    = 40,
  parameter int                MEM_DEPTH = 1024,
  parameter logic [AXI_AW-1:0] BASE_ADDR = '0,
  parameter int                SLV_WS    = 1,
  parameter int                CNT_W     = 32,
  localparam int               AXI_BYTES = AXI_DW / 8
) (
  input  logic                 usr_clk,
  input  logic                 usr_reset,
  input  logic [AXI_AW-1:0]    m_addr,
  input  logic [AXI_DW-1:0]    m_wdata,
  input  logic [AXI_BYTES-1:0] m_wstrb,
  input  logic                 m_we,
  input  logic                 m_re,
  output logic [AXI_DW-1:0]    m_rdata,
  input  logic                 clr_stat,
  output logic                 err_oob,
  output logic                 err_coll,
  output logic [CNT_W-1:0]     wr_cnt,
  output logic [CNT_W-1:0]     rd_cnt
);

  localparam int                OFF_SH  = $clog2(AXI_BYTES);
  localparam int                IW      = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [AXI_AW-1:0] DEPTH_W = AXI_AW'(MEM_DEPTH);

  logic [AXI_DW-1:0] mem_q [MEM_DEPTH];

  logic [AXI_AW-1:0] off;
  logic [AXI_AW-1:0] idx;
  logic [IW-1:0]     widx;
  logic              in_range;

  logic              wr_fire;
  logic              rd_fire;
  logic              coll_evt;
  logic              wr_en;
  logic [AXI_DW-1:0] rd_word;

  logic              fin_vld;
  logic [AXI_DW-1:0] fin_data;
  logic [AXI_DW-1:0] rdata_d, rdata_q;

  logic [CNT_W-1:0]  wr_cnt_d, wr_cnt_q;
  logic [CNT_W-1:0]  rd_cnt_d, rd_cnt_q;
  logic              err_oob_d, err_oob_q;
  logic              err_coll_d, err_coll_q;

  // Address decode at full address width; a below-base address is rejected
  // explicitly so the subtraction wrapping around can never look in range.
  always_comb begin
    off      = m_addr - BASE_ADDR;
    idx      = off >> OFF_SH;
    in_range = (m_addr >= BASE_ADDR) && (idx < DEPTH_W);
    widx     = idx[IW-1:0];
  end

  // Qualify requests: nothing is accepted under reset, and a collision turns
  // the read into a no-op while the write proceeds.
  always_comb begin
    wr_fire  = m_we & ~usr_reset;
    rd_fire  = m_re & ~m_we & ~usr_reset;
    coll_evt = m_we & m_re & ~usr_reset;
    wr_en    = wr_fire & in_range;
    rd_word  = '0;
    if (in_range) begin
      rd_word = mem_q[widx];
    end
  end

  // Byte-strobed array write; the array itself is deliberately not reset.
  always_ff @(posedge usr_clk) begin
    if (wr_en) begin
      for (int i = 0; i < AXI_BYTES; i++) begin
        if (m_wstrb[i]) begin
          mem_q[widx][8*i +: 8] <= m_wdata[8*i +: 8];
        end
      end
    end
  end

  generate
    if (SLV_WS >= 2) begin : g_pipe
      localparam int PS = SLV_WS - 1;

      logic [PS-1:0]     pv_d, pv_q;
      logic [AXI_DW-1:0] pd_d [PS];
      logic [AXI_DW-1:0] pd_q [PS];

      // Shift read-valid and read data down the latency pipeline; stage 0
      // is the registered array read.
      always_comb begin
        pv_d    = '0;
        pv_d[0] = rd_fire;
        pd_d[0] = rd_word;
        for (int k = 1; k < PS; k++) begin
          pv_d[k] = pv_q[k-1];
          pd_d[k] = pd_q[k-1];
        end
      end

      // Valid bits are flushed by reset so in-flight reads never complete.
      always_ff @(posedge usr_clk) begin
        if (usr_reset) begin
          pv_q <= '0;
        end else begin
          pv_q <= pv_d;
        end
      end

      // Pipeline data needs no reset; it is only consumed with its valid bit.
      always_ff @(posedge usr_clk) begin
        pd_q <= pd_d;
      end

      assign fin_vld  = pv_q[PS-1];
      assign fin_data = pd_q[PS-1];
    end else begin : g_nopipe
      assign fin_vld  = rd_fire;
      assign fin_data = rd_word;
    end
  endgenerate

  // Read data holds its last value unless a read completes this cycle.
  always_comb begin
    rdata_d = rdata_q;
    if (fin_vld) begin
      rdata_d = fin_data;
    end
  end

  // Output data register, also used as the hold value in zero-latency mode.
  always_ff @(posedge usr_clk) begin
    if (usr_reset) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign m_rdata = (SLV_WS == 0) ? rdata_d : rdata_q;

  // Statistics update: clear wins over any same-cycle event, counters saturate.
  always_comb begin
    wr_cnt_d   = wr_cnt_q;
    rd_cnt_d   = rd_cnt_q;
    err_oob_d  = err_oob_q;
    err_coll_d = err_coll_q;
    if (clr_stat) begin
      wr_cnt_d   = '0;
      rd_cnt_d   = '0;
      err_oob_d  = 1'b0;
      err_coll_d = 1'b0;
    end else begin
      if (wr_en && (wr_cnt_q != '1)) begin
        wr_cnt_d = wr_cnt_q + CNT_W'(1);
      end
      if (rd_fire && in_range && (rd_cnt_q != '1)) begin
        rd_cnt_d = rd_cnt_q + CNT_W'(1);
      end
      if ((wr_fire || rd_fire) && !in_range) begin
        err_oob_d = 1'b1;
      end
      if (coll_evt) begin
        err_coll_d = 1'b1;
      end
    end
  end

  // Statistics registers.
  always_ff @(posedge usr_clk) begin
    if (usr_reset) begin
      wr_cnt_q   <= '0;
      rd_cnt_q   <= '0;
      err_oob_q  <= 1'b0;
      err_coll_q <= 1'b0;
    end else begin
      wr_cnt_q   <= wr_cnt_d;
      rd_cnt_q   <= rd_cnt_d;
      err_oob_q  <= err_oob_d;
      err_coll_q <= err_coll_d;
    end
  end

  assign wr_cnt   = wr_cnt_q;
  assign rd_cnt   = rd_cnt_q;
  assign err_oob  = err_oob_q;
  assign err_coll = err_coll_q;

endmodule

// File: tb/tb_asi_usr_mem.sv
// Directed bench for asi_usr_mem.
// Four instances share one stimulus stream: latency 0, latency 1, latency 3,
// and a 4-bit counter build. All use BASE_ADDR 0x1000.
module tb_asi_usr_mem;

  localparam logic [39:0] BASE = 40'h1000;
  localparam logic [127:0] EXP_B0 = 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FF00;
  localparam logic [127:0] EXP_AB = 128'hABFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FF00;

  logic         usr_clk = 1'b0;
  logic         usr_reset;
  logic [39:0]  m_addr;
  logic [127:0] m_wdata;
  logic [15:0]  m_wstrb;
  logic         m_we;
  logic         m_re;
  logic         clr_stat;

  logic [127:0] rdata_ws0, rdata_ws1, rdata_ws3, rdata_c4;
  logic         oob_ws0, oob_ws1, oob_ws3, oob_c4;
  logic         coll_ws0, coll_ws1, coll_ws3, coll_c4;
  logic [31:0]  wcnt_ws0, wcnt_ws1, wcnt_ws3;
  logic [31:0]  rcnt_ws0, rcnt_ws1, rcnt_ws3;
  logic [3:0]   wcnt_c4, rcnt_c4;

  int total = 0;
  int bad   = 0;

  always #5 usr_clk = ~usr_clk;

  asi_usr_mem #(.BASE_ADDR(BASE), .SLV_WS(0)) u_ws0 (
    .usr_clk(usr_clk), .usr_reset(usr_reset), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_wstrb(m_wstrb), .m_we(m_we), .m_re(m_re), .m_rdata(rdata_ws0),
    .clr_stat(clr_stat), .err_oob(oob_ws0), .err_coll(coll_ws0),
    .wr_cnt(wcnt_ws0), .rd_cnt(rcnt_ws0));

  asi_usr_mem #(.BASE_ADDR(BASE), .SLV_WS(1)) u_ws1 (
    .usr_clk(usr_clk), .usr_reset(usr_reset), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_wstrb(m_wstrb), .m_we(m_we), .m_re(m_re), .m_rdata(rdata_ws1),
    .clr_stat(clr_stat), .err_oob(oob_ws1), .err_coll(coll_ws1),
    .wr_cnt(wcnt_ws1), .rd_cnt(rcnt_ws1));

  asi_usr_mem #(.BASE_ADDR(BASE), .SLV_WS(3)) u_ws3 (
    .usr_clk(usr_clk), .usr_reset(usr_reset), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_wstrb(m_wstrb), .m_we(m_we), .m_re(m_re), .m_rdata(rdata_ws3),
    .clr_stat(clr_stat), .err_oob(oob_ws3), .err_coll(coll_ws3),
    .wr_cnt(wcnt_ws3), .rd_cnt(rcnt_ws3));

  asi_usr_mem #(.BASE_ADDR(BASE), .SLV_WS(1), .CNT_W(4)) u_c4 (
    .usr_clk(usr_clk), .usr_reset(usr_reset), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_wstrb(m_wstrb), .m_we(m_we), .m_re(m_re), .m_rdata(rdata_c4),
    .clr_stat(clr_stat), .err_oob(oob_c4), .err_coll(coll_c4),
    .wr_cnt(wcnt_c4), .rd_cnt(rcnt_c4));

  // Advance one clock and sample 1 ns after the edge.
  task automatic tick();
    @(posedge usr_clk);
    #1;
  endtask

  // Single-cycle write request.
  task automatic wr(input logic [39:0] a, input logic [127:0] d, input logic [15:0] s);
    m_addr  = a;
    m_wdata = d;
    m_wstrb = s;
    m_we    = 1'b1;
    tick();
    m_we    = 1'b0;
  endtask

  // Single-cycle read request.
  task automatic rd(input logic [39:0] a);
    m_addr = a;
    m_re   = 1'b1;
    tick();
    m_re   = 1'b0;
  endtask

  // Reset brings all outputs to zero.
  task automatic test_reset();
    usr_reset = 1'b1;
    m_addr = '0; m_wdata = '0; m_wstrb = '0;
    m_we = 1'b0; m_re = 1'b0; clr_stat = 1'b0;
    tick();
    tick();
    usr_reset = 1'b0;
    total++; if (rdata_ws1 !== 128'h0) begin bad++; $display("[TB] FAIL reset_rdata_ws1: got %h want 0", rdata_ws1); end
    total++; if (rdata_ws3 !== 128'h0) begin bad++; $display("[TB] FAIL reset_rdata_ws3: got %h want 0", rdata_ws3); end
    total++; if (rdata_ws0 !== 128'h0) begin bad++; $display("[TB] FAIL reset_rdata_ws0: got %h want 0", rdata_ws0); end
    total++; if (oob_ws1 !== 1'b0) begin bad++; $display("[TB] FAIL reset_oob: got %b want 0", oob_ws1); end
    total++; if (coll_ws1 !== 1'b0) begin bad++; $display("[TB] FAIL reset_coll: got %b want 0", coll_ws1); end
    total++; if (wcnt_ws1 !== 32'd0) begin bad++; $display("[TB] FAIL reset_wcnt: got %0d want 0", wcnt_ws1); end
    total++; if (rcnt_ws1 !== 32'd0) begin bad++; $display("[TB] FAIL reset_rcnt: got %0d want 0", rcnt_ws1); end
  endtask

  // Full-strobe write followed immediately by a read of the same word.
  task automatic test_write_read();
    wr(40'h1010, 128'h0011223344, 16'hFFFF);
    m_addr = 40'h1010;
    m_re   = 1'b1;
    #1;
    total++; if (rdata_ws0 !== 128'h0011223344) begin bad++; $display("[TB] FAIL wr_rd_ws0_comb: got %h want %h", rdata_ws0, 128'h0011223344); end
    tick();
    m_re = 1'b0;
    total++; if (rdata_ws1 !== 128'h0011223344) begin bad++; $display("[TB] FAIL wr_rd_ws1: got %h want %h", rdata_ws1, 128'h0011223344); end
    total++; if (wcnt_ws1 !== 32'd1) begin bad++; $display("[TB] FAIL wr_rd_wcnt: got %0d want 1", wcnt_ws1); end
    total++; if (rcnt_ws1 !== 32'd1) begin bad++; $display("[TB] FAIL wr_rd_rcnt: got %0d want 1", rcnt_ws1); end
    tick();
    tick();
    total++; if (rdata_ws3 !== 128'h0011223344) begin bad++; $display("[TB] FAIL wr_rd_ws3: got %h want %h", rdata_ws3, 128'h0011223344); end
  endtask

  // Partial strobes touch only the selected bytes.
  task automatic test_strobe();
    wr(40'h1000, {128{1'b1}}, 16'hFFFF);
    wr(40'h1000, 128'h0, 16'h0001);
    rd(40'h1000);
    total++; if (rdata_ws1 !== EXP_B0) begin bad++; $display("[TB] FAIL strobe_byte0: got %h want %h", rdata_ws1, EXP_B0); end
    wr(40'h1000, 128'hAB00_0000_0000_0000_0000_0000_0000_0000, 16'h8000);
    rd(40'h1000);
    total++; if (rdata_ws1 !== EXP_AB) begin bad++; $display("[TB] FAIL strobe_byte15: got %h want %h", rdata_ws1, EXP_AB); end
    tick();
    tick();
    total++; if (rdata_ws3 !== EXP_AB) begin bad++; $display("[TB] FAIL strobe_ws3: got %h want %h", rdata_ws3, EXP_AB); end
  endtask

  // Back-to-back reads through the 3-deep pipeline.
  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      wr(BASE + 40'(16 * i), 128'(i), 16'hFFFF);
    end
    for (int i = 0; i < 7; i++) begin
      if (i < 4) begin
        m_addr = BASE + 40'(16 * i);
        m_re   = 1'b1;
      end else begin
        m_re   = 1'b0;
      end
      tick();
      if (i < 4) begin
        total++; if (rdata_ws1 !== 128'(i)) begin bad++; $display("[TB] FAIL b2b_ws1[%0d]: got %h want %h", i, rdata_ws1, 128'(i)); end
      end
      if (i < 2) begin
        total++; if (rdata_ws3 !== EXP_AB) begin bad++; $display("[TB] FAIL b2b_ws3_hold[%0d]: got %h want %h", i, rdata_ws3, EXP_AB); end
      end else begin
        total++; if (rdata_ws3 !== 128'((i < 6) ? i - 2 : 3)) begin bad++; $display("[TB] FAIL b2b_ws3[%0d]: got %h want %0d", i, rdata_ws3, (i < 6) ? i - 2 : 3); end
      end
    end
  endtask

  // Window edges, out-of-range accesses and clearing the flags.
  task automatic test_oob();
    wr(40'h4FF0, 128'hBEEF, 16'hFFFF);
    rd(40'h4FF0);
    total++; if (rdata_ws1 !== 128'hBEEF) begin bad++; $display("[TB] FAIL oob_last_word: got %h want %h", rdata_ws1, 128'hBEEF); end
    total++; if (oob_ws1 !== 1'b0) begin bad++; $display("[TB] FAIL oob_inrange_flag: got %b want 0", oob_ws1); end
    rd(40'h0FF0);
    total++; if (rdata_ws1 !== 128'h0) begin bad++; $display("[TB] FAIL oob_below: got %h want 0", rdata_ws1); end
    total++; if (oob_ws1 !== 1'b1) begin bad++; $display("[TB] FAIL oob_below_flag: got %b want 1", oob_ws1); end
    rd(40'h4FF0);
    rd(40'h5000);
    total++; if (rdata_ws1 !== 128'h0) begin bad++; $display("[TB] FAIL oob_above: got %h want 0", rdata_ws1); end
    wr(40'h0FF0, 128'h1234, 16'hFFFF);
    total++; if (wcnt_ws1 !== 32'd9) begin bad++; $display("[TB] FAIL oob_wcnt: got %0d want 9", wcnt_ws1); end
    total++; if (rcnt_ws1 !== 32'd9) begin bad++; $display("[TB] FAIL oob_rcnt: got %0d want 9", rcnt_ws1); end
    total++; if (wcnt_c4 !== 4'd9) begin bad++; $display("[TB] FAIL oob_wcnt_c4: got %0d want 9", wcnt_c4); end
    total++; if (coll_ws1 !== 1'b0) begin bad++; $display("[TB] FAIL oob_coll_flag: got %b want 0", coll_ws1); end
    clr_stat = 1'b1;
    tick();
    clr_stat = 1'b0;
    total++; if (oob_ws1 !== 1'b0) begin bad++; $display("[TB] FAIL clr_oob: got %b want 0", oob_ws1); end
    total++; if (wcnt_ws1 !== 32'd0) begin bad++; $display("[TB] FAIL clr_wcnt: got %0d want 0", wcnt_ws1); end
    total++; if (rcnt_ws1 !== 32'd0) begin bad++; $display("[TB] FAIL clr_rcnt: got %0d want 0", rcnt_ws1); end
  endtask

  // Write and read in one cycle: write lands, read is dropped.
  task automatic test_collision();
    rd(40'h1010);
    total++; if (rdata_ws1 !== 128'h1) begin bad++; $display("[TB] FAIL coll_pre_read: got %h want 1", rdata_ws1); end
    m_addr  = 40'h1050;
    m_wdata = 128'hA5;
    m_wstrb = 16'hFFFF;
    m_we    = 1'b1;
    m_re    = 1'b1;
    #1;
    total++; if (rdata_ws0 !== 128'h1) begin bad++; $display("[TB] FAIL coll_ws0_hold: got %h want 1", rdata_ws0); end
    tick();
    m_we = 1'b0;
    m_re = 1'b0;
    total++; if (rdata_ws1 !== 128'h1) begin bad++; $display("[TB] FAIL coll_ws1_hold: got %h want 1", rdata_ws1); end
    total++; if (coll_ws1 !== 1'b1) begin bad++; $display("[TB] FAIL coll_flag: got %b want 1", coll_ws1); end
    total++; if (wcnt_ws1 !== 32'd1) begin bad++; $display("[TB] FAIL coll_wcnt: got %0d want 1", wcnt_ws1); end
    total++; if (rcnt_ws1 !== 32'd1) begin bad++; $display("[TB] FAIL coll_rcnt: got %0d want 1", rcnt_ws1); end
    tick();
    total++; if (rdata_ws3 !== 128'h1) begin bad++; $display("[TB] FAIL coll_ws3_pre: got %h want 1", rdata_ws3); end
    tick();
    total++; if (rdata_ws3 !== 128'h1) begin bad++; $display("[TB] FAIL coll_ws3_hold: got %h want 1", rdata_ws3); end
    rd(40'h1050);
    total++; if (rdata_ws1 !== 128'hA5) begin bad++; $display("[TB] FAIL coll_readback: got %h want a5", rdata_ws1); end
    total++; if (rcnt_ws1 !== 32'd2) begin bad++; $display("[TB] FAIL coll_rcnt_after: got %0d want 2", rcnt_ws1); end
  endtask

  // Clear in the same cycle as a flaggable event.
  task automatic test_clear_priority();
    m_addr   = 40'h0FF0;
    m_wdata  = 128'h55;
    m_wstrb  = 16'hFFFF;
    m_we     = 1'b1;
    clr_stat = 1'b1;
    tick();
    m_we     = 1'b0;
    clr_stat = 1'b0;
    total++; if (oob_ws1 !== 1'b0) begin bad++; $display("[TB] FAIL clrpri_oob: got %b want 0", oob_ws1); end
    total++; if (coll_ws1 !== 1'b0) begin bad++; $display("[TB] FAIL clrpri_coll: got %b want 0", coll_ws1); end
    total++; if (rcnt_ws1 !== 32'd0) begin bad++; $display("[TB] FAIL clrpri_rcnt: got %0d want 0", rcnt_ws1); end
  endtask

  // Narrow counter saturates while the wide one keeps counting.
  task automatic test_saturate();
    for (int i = 0; i < 20; i++) begin
      wr(40'h1060, 128'(i), 16'hFFFF);
      if (i == 14) begin
        total++; if (wcnt_c4 !== 4'd15) begin bad++; $display("[TB] FAIL sat_c4_at15: got %0d want 15", wcnt_c4); end
      end
    end
    total++; if (wcnt_c4 !== 4'd15) begin bad++; $display("[TB] FAIL sat_c4_final: got %0d want 15", wcnt_c4); end
    total++; if (wcnt_ws1 !== 32'd20) begin bad++; $display("[TB] FAIL sat_ws1: got %0d want 20", wcnt_ws1); end
    rd(40'h1060);
    total++; if (rdata_ws1 !== 128'd19) begin bad++; $display("[TB] FAIL sat_readback: got %h want 19", rdata_ws1); end
  endtask

  // Reset in the middle of a latency-3 read flushes it.
  task automatic test_reset_midread();
    rd(40'h1020);
    usr_reset = 1'b1;
    m_addr    = 40'h1020;
    m_wdata   = 128'h77;
    m_wstrb   = 16'hFFFF;
    m_we      = 1'b1;
    tick();
    usr_reset = 1'b0;
    m_we      = 1'b0;
    total++; if (rdata_ws3 !== 128'h0) begin bad++; $display("[TB] FAIL rst_mid_ws3: got %h want 0", rdata_ws3); end
    total++; if (rdata_ws1 !== 128'h0) begin bad++; $display("[TB] FAIL rst_mid_ws1: got %h want 0", rdata_ws1); end
    for (int i = 0; i < 4; i++) begin
      tick();
      total++; if (rdata_ws3 !== 128'h0) begin bad++; $display("[TB] FAIL rst_stale[%0d]: got %h want 0", i, rdata_ws3); end
    end
    total++; if (wcnt_ws1 !== 32'd0) begin bad++; $display("[TB] FAIL rst_wcnt: got %0d want 0", wcnt_ws1); end
    total++; if (rcnt_ws3 !== 32'd0) begin bad++; $display("[TB] FAIL rst_rcnt: got %0d want 0", rcnt_ws3); end
    total++; if (wcnt_c4 !== 4'd0) begin bad++; $display("[TB] FAIL rst_wcnt_c4: got %0d want 0", wcnt_c4); end
    total++; if ({oob_ws3, coll_ws3} !== 2'b00) begin bad++; $display("[TB] FAIL rst_flags: got %b want 00", {oob_ws3, coll_ws3}); end
    rd(40'h1020);
    total++; if (rdata_ws1 !== 128'h2) begin bad++; $display("[TB] FAIL rst_ignored_write: got %h want 2", rdata_ws1); end
    tick();
    tick();
    total++; if (rdata_ws3 !== 128'h2) begin bad++; $display("[TB] FAIL rst_ws3_recover: got %h want 2", rdata_ws3); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_strobe();
    test_back_to_back();
    test_oob();
    test_collision();
    test_clear_priority();
    test_saturate();
    test_reset_midread();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/asi_usr_mem.md
Name: asi_usr_mem

Overview:
- User-side memory slave on the downstream side of the AXI slave interface, in the usr_clk domain.
- Consumes the single-port request stream (m_addr, m_we/m_wstrb/m_wdata, m_re) and returns m_rdata exactly SLV_WS cycles after m_re, matching the interface's read-valid timing.
- Provides byte-strobed writes, address-window decode, out-of-range/collision error flags and saturating access counters.
- Serves as the default functional endpoint in subsystem and bench builds.

Parameters:
- AXI_DW, 128, data width; must equal the interface's AXI_DW.
- AXI_AW, 40, byte address width.
- MEM_DEPTH, 1024, number of AXI_DW-bit words.
- BASE_ADDR, 0, byte address of word 0; must be AXI_BYTES-aligned.
- SLV_WS, 1, read latency in cycles (0, 1 or N>=2); must equal the interface's SLV_WS.
- CNT_W, 32, width of the access counters.
- AXI_BYTES, AXI_DW/8, derived; bytes per word and strobe width.

Ports:
- usr_clk  in  1  user clock.
- usr_reset  in  1  synchronous, active-high reset.
- m_addr  in  AXI_AW  byte address of the current request.
- m_wdata  in  AXI_DW  write data.
- m_wstrb  in  AXI_BYTES  byte enables; bit i covers m_wdata[8i+7:8i].
- m_we  in  1  write request, single-cycle strobe.
- m_re  in  1  read request, single-cycle strobe.
- m_rdata  out  AXI_DW  read data.
- clr_stat  in  1  clears counters and sticky flags.
- err_oob  out  1  sticky: an access fell outside the window.
- err_coll  out  1  sticky: m_we and m_re were both high in one cycle.
- wr_cnt  out  CNT_W  accepted in-range writes, saturating.
- rd_cnt  out  CNT_W  accepted in-range reads, saturating.

Behaviour:
- One clock domain. Reset is synchronous and active-high: usr_clk and usr_reset; usr_reset is sampled only on the rising edge of usr_clk.
- Reset values: m_rdata=0, err_oob=0, err_coll=0, wr_cnt=0, rd_cnt=0, read pipeline flushed. Array contents are not reset.
- Decode:
  - off = m_addr - BASE_ADDR; idx = off >> log2(AXI_BYTES); low address bits are ignored.
  - In range iff m_addr >= BASE_ADDR and idx < MEM_DEPTH; compare at full AXI_AW width, with no wrap.
- Write (m_we=1, in range): each byte i with m_wstrb[i]=1 is updated at the clock edge; other bytes are unchanged. m_wstrb=0 is a legal no-op write and still counts.
- Read (m_re=1, m_we=0, in range):
  - SLV_WS=0: m_rdata = mem[idx] combinationally in the same cycle.
  - SLV_WS=1: m_rdata is registered and valid on the cycle after m_re.
  - SLV_WS=N>=2: registered array read plus N-1 further pipeline stages; valid exactly N cycles after m_re.
  - Back-to-back reads on consecutive cycles are supported at full throughput.
- m_rdata holds its last value when no read is completing; the consumer samples it only at read-valid time.
- Read-after-write: a read issued the cycle after a write to the same word returns the new data.
- Out of range:
  - Write: dropped, err_oob set.
  - Read: returns 0 with normal latency, err_oob set.
  - Neither is counted.
- Collision (m_we & m_re):
  - The write executes per the rules above. The read is discarded, with no data delivered at read-valid time and m_rdata holding its value. err_coll is set.
  - Only the write counts.
- Counters increment by 1 per accepted access and saturate at all-ones.
- clr_stat: at the next edge, counters and flags go to 0. Clear has priority over a same-cycle event, which is neither counted nor flagged.
- Reset asserted mid-read: in-flight reads are dropped and m_rdata=0 from the next edge. Requests presented while usr_reset=1 are ignored.

Test Plan:
- SLV_WS=1, BASE_ADDR=0x1000: write 0x…0011223344 to 0x1010 with full strobe; m_re to 0x1010 at cycle t -> m_rdata equals the written data at t+1; wr_cnt=1, rd_cnt=1.
- Write all-0xFF to 0x1000, then write 0x00 with m_wstrb=0x0001 -> read gives byte0=0x00 and bytes1..15=0xFF.
- SLV_WS=3: m_re on 4 consecutive cycles to words 0..3 (preloaded 0..3) -> m_rdata shows 0,1,2,3 on cycles t+3..t+6.
- Read from 0x0FF0 (below base) and from BASE_ADDR+MEM_DEPTH*16 -> m_rdata=0 at read-valid time, err_oob=1, counters unchanged; then pulse clr_stat -> err_oob=0.
- m_we=m_re=1 in one cycle to word 5 with data 0xA5 -> word 5 reads back 0xA5 later; err_coll=1; wr_cnt+1, rd_cnt unchanged; m_rdata unchanged at the would-be read-valid cycle.
- CNT_W=4: issue 20 writes -> wr_cnt saturates at 15. Assert usr_reset during a SLV_WS=3 read -> m_rdata=0 from the next edge, stale data never appears, and all counters and flags read 0.
